// File: rtl/pipelined_mips_cpu_pkg.sv
// Shared opcode/funct constants, ALU-op and forward-select enums, and the pipeline-register structs.
// Latency: none (types only); backpressure: n/a.
package pipelined_mips_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;
    typedef enum logic [1:0] {FWD_NONE, FWD_WB, FWD_MEM, FWD_EX} fwd_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr_reg;
    } id_ex_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  wr_reg;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [4:0]  wr_reg;
    } mem_wb_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/pipelined_mips_cpu_units.sv
// PC register, instruction/data memories, register file and the hazard/forwarding logic.
// Latency: PC and memory/regfile writes 1 cycle, reads combinational; backpressure: PC holds when en is low.
module mips_pc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] target,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)   pc_o <= 32'd0;
        else if (en) pc_o <= load ? target : pc_o + 32'd4;
    end
endmodule

module mips_imem #(parameter int WORDS = 256) (
    input  logic [7:0]  addr,
    output logic [31:0] instr
);
    logic [31:0] memory [0:WORDS-1];
    assign instr = memory[addr];
endmodule

module mips_dmem #(parameter int WORDS = 256) (
    input  logic        clk_i,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] memory [0:WORDS-1];
    always_ff @(posedge clk_i) begin
        if (we) memory[addr] <= wdata;
    end
    assign rdata = memory[addr];
endmodule

module mips_regfile #(parameter int NUM_REGS = 32) (
    input  logic        clk_i,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] register [0:NUM_REGS-1];
    always_ff @(posedge clk_i) begin
        if (we && wa != 5'd0) register[wa] <= wd;
    end
    // Same-cycle WB write is visible to the ID read
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : (we && wa == ra1) ? wd : register[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : (we && wa == ra2) ? wd : register[ra2];
endmodule

module hazard_forward_unit import pipelined_mips_cpu_pkg::*; (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_wr_reg,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_wr_reg,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_wr_reg,
    input  logic       wb_reg_write,
    output logic       stall,
    output fwd_sel_e   fwd_a,
    output fwd_sel_e   fwd_b,
    output fwd_sel_e   fwd_id_a,
    output fwd_sel_e   fwd_id_b
);
    logic mem_ok, wb_ok, ex_ok;
    assign mem_ok = mem_reg_write && mem_wr_reg != 5'd0;
    assign wb_ok  = wb_reg_write  && wb_wr_reg  != 5'd0;
    assign ex_ok  = ex_reg_write  && ex_wr_reg  != 5'd0;

    assign stall = ex_mem_read && ex_rt != 5'd0 && (ex_rt == id_rs || ex_rt == id_rt);

    assign fwd_a = (mem_ok && mem_wr_reg == ex_rs) ? FWD_MEM : (wb_ok && wb_wr_reg == ex_rs) ? FWD_WB : FWD_NONE;
    assign fwd_b = (mem_ok && mem_wr_reg == ex_rt) ? FWD_MEM : (wb_ok && wb_wr_reg == ex_rt) ? FWD_WB : FWD_NONE;

    // Branch compare in ID: WB results already arrive through the register-file bypass
    assign fwd_id_a = (ex_ok && ex_wr_reg == id_rs) ? FWD_EX : (mem_ok && mem_wr_reg == id_rs) ? FWD_MEM : FWD_NONE;
    assign fwd_id_b = (ex_ok && ex_wr_reg == id_rt) ? FWD_EX : (mem_ok && mem_wr_reg == id_rt) ? FWD_MEM : FWD_NONE;
endmodule

// File: rtl/pipelined_mips_cpu.sv
// Five-stage MIPS-subset core (IF/ID/EX/MEM/WB) with load-use stall, forwarding and ID-stage branch resolution.
// Latency: 5-cycle fill, one instruction per cycle; backpressure: start_i low freezes the whole core, load-use stalls one cycle.
module pipelined_mips_cpu import pipelined_mips_cpu_pkg::*; #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256,
    parameter int NUM_REGS   = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i
);
    if_id_t  if_id;
    id_ex_t  id_ex, id_ex_d;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic        IF_stall_signal, IF_flush_signal;
    logic [31:0] pc, pc_plus4, fetch_instr;
    logic [31:0] rs_raw, rt_raw, id_rs_val, id_rt_val, id_imm;
    logic [31:0] branch_target, alu_y, op_a, rt_fwd, op_b;
    logic [31:0] ex_mem_result, wb_value, dmem_rdata;
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, dec_wr_reg;
    logic        is_beq, is_j, branch_taken;
    ctrl_t       dec_ctrl;
    fwd_sel_e    fwd_a, fwd_b, fwd_id_a, fwd_id_b;

    // ---------------- IF ----------------
    assign pc_plus4 = pc + 32'd4;

    mips_pc PC (
        .clk_i(clk_i), .rst_i(rst_i), .en(start_i && !IF_stall_signal),
        .load(branch_taken), .target(branch_target), .pc_o(pc)
    );

    mips_imem #(.WORDS(IMEM_WORDS)) Instruction_Memory (.addr(pc[9:2]), .instr(fetch_instr));

    // ---------------- ID ----------------
    assign id_op    = if_id.instr[31:26];
    assign id_rs    = if_id.instr[25:21];
    assign id_rt    = if_id.instr[20:16];
    assign id_rd    = if_id.instr[15:11];
    assign id_funct = if_id.instr[5:0];
    assign id_imm   = sext16(if_id.instr[15:0]);

    always_comb begin
        dec_ctrl   = NOP_CTRL;
        dec_wr_reg = 5'd0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        case (id_op)
            OP_RTYPE: begin
                dec_ctrl.reg_write = 1'b1;
                dec_wr_reg         = id_rd;
                case (id_funct)
                    FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
                    FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
                    FN_AND:  dec_ctrl.alu_op = ALU_AND;
                    FN_OR:   dec_ctrl.alu_op = ALU_OR;
                    FN_MUL:  dec_ctrl.alu_op = ALU_MUL;
                    default: begin
                        dec_ctrl.reg_write = 1'b0;
                        dec_wr_reg         = 5'd0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_wr_reg         = id_rt;
            end
            OP_LW: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_wr_reg          = id_rt;
            end
            OP_SW: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_J:    is_j   = 1'b1;
            default: ;
        endcase
    end

    mips_regfile #(.NUM_REGS(NUM_REGS)) Registers (
        .clk_i(clk_i), .we(mem_wb.ctrl.reg_write), .wa(mem_wb.wr_reg), .wd(wb_value),
        .ra1(id_rs), .ra2(id_rt), .rd1(rs_raw), .rd2(rt_raw)
    );

    hazard_forward_unit hfu (
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(id_ex.rs), .ex_rt(id_ex.rt),
        .ex_wr_reg(id_ex.wr_reg), .ex_reg_write(id_ex.ctrl.reg_write), .ex_mem_read(id_ex.ctrl.mem_read),
        .mem_wr_reg(ex_mem.wr_reg), .mem_reg_write(ex_mem.ctrl.reg_write),
        .wb_wr_reg(mem_wb.wr_reg), .wb_reg_write(mem_wb.ctrl.reg_write),
        .stall(IF_stall_signal), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b)
    );

    assign id_rs_val = (fwd_id_a == FWD_EX) ? alu_y : (fwd_id_a == FWD_MEM) ? ex_mem_result : rs_raw;
    assign id_rt_val = (fwd_id_b == FWD_EX) ? alu_y : (fwd_id_b == FWD_MEM) ? ex_mem_result : rt_raw;

    assign branch_taken    = is_j || (is_beq && id_rs_val == id_rt_val);
    assign branch_target   = is_j ? {if_id.pc4[31:28], if_id.instr[25:0], 2'b00} : if_id.pc4 + (id_imm << 2);
    assign IF_flush_signal = branch_taken && !IF_stall_signal;

    always_comb begin
        id_ex_d        = '0;
        id_ex_d.ctrl   = dec_ctrl;
        id_ex_d.rs_val = rs_raw;
        id_ex_d.rt_val = rt_raw;
        id_ex_d.imm    = id_imm;
        id_ex_d.rs     = id_rs;
        id_ex_d.rt     = id_rt;
        id_ex_d.wr_reg = dec_wr_reg;
    end

    // ---------------- EX ----------------
    always_comb begin
        case (fwd_a)
            FWD_MEM: op_a = ex_mem_result;
            FWD_WB:  op_a = wb_value;
            default: op_a = id_ex.rs_val;
        endcase
        case (fwd_b)
            FWD_MEM: rt_fwd = ex_mem_result;
            FWD_WB:  rt_fwd = wb_value;
            default: rt_fwd = id_ex.rt_val;
        endcase
        op_b = id_ex.ctrl.alu_src ? id_ex.imm : rt_fwd;
        case (id_ex.ctrl.alu_op)
            ALU_SUB: alu_y = op_a - op_b;
            ALU_AND: alu_y = op_a & op_b;
            ALU_OR:  alu_y = op_a | op_b;
            ALU_MUL: alu_y = op_a * op_b;
            default: alu_y = op_a + op_b;
        endcase
    end

    // ---------------- MEM / WB ----------------
    mips_dmem #(.WORDS(DMEM_WORDS)) Data_Memory (
        .clk_i(clk_i), .we(ex_mem.ctrl.mem_write), .addr(ex_mem.alu_result[7:0]),
        .wdata(ex_mem.store_data), .rdata(dmem_rdata)
    );

    assign ex_mem_result = ex_mem.ctrl.mem_to_reg ? dmem_rdata : ex_mem.alu_result;
    assign wb_value      = mem_wb.ctrl.mem_to_reg ? mem_wb.mem_data : mem_wb.alu_result;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else if (start_i) begin
            if (!IF_stall_signal) begin
                if (IF_flush_signal) begin
                    if_id <= '0;
                end else begin
                    if_id.pc4   <= pc_plus4;
                    if_id.instr <= fetch_instr;
                end
            end
            id_ex <= IF_stall_signal ? '0 : id_ex_d;
            ex_mem.ctrl       <= id_ex.ctrl;
            ex_mem.alu_result <= alu_y;
            ex_mem.store_data <= rt_fwd;
            ex_mem.wr_reg     <= id_ex.wr_reg;
            mem_wb.ctrl       <= ex_mem.ctrl;
            mem_wb.alu_result <= ex_mem.alu_result;
            mem_wb.mem_data   <= dmem_rdata;
            mem_wb.wr_reg     <= ex_mem.wr_reg;
        end
    end
endmodule

// File: tb/tb_pipelined_mips_cpu.sv
// Self-checking bench: directed scenarios plus random programs against an instruction-level reference model.
module tb_pipelined_mips_cpu;
    localparam logic [5:0] T_RTYPE = 6'h00, T_J = 6'h02, T_BEQ = 6'h04, T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2B;
    localparam logic [5:0] T_ADD = 6'h20, T_SUB = 6'h22, T_AND = 6'h24, T_OR = 6'h25, T_MUL = 6'h18;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic start_i = 1'b0;
    always #5 clk_i = ~clk_i;

    pipelined_mips_cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] prog  [0:255];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:255];
    logic [31:0] pc_tr [0:255];
    logic        st_tr [0:255];
    logic        fl_tr [0:255];

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {T_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] a);
        return {T_J, a};
    endfunction

    task automatic init_model();
        for (int i = 0; i < 256; i++) begin
            prog[i]  = 32'd0;
            m_mem[i] = $urandom;
        end
        m_reg[0] = 32'd0;
        for (int r = 1; r < 32; r++) m_reg[r] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
    endtask

    // Copy program and initial state into the core while reset holds, then release with start high.
    task automatic start_run();
        rst_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 256; i++) begin
            dut.Instruction_Memory.memory[i] = prog[i];
            dut.Data_Memory.memory[i] = m_mem[i];
        end
        for (int r = 0; r < 32; r++) dut.Registers.register[r] = m_reg[r];
        @(negedge clk_i);
        rst_i = 1'b0;
        start_i = 1'b1;
    endtask

    task automatic run(input int n);
        pc_tr[0] = dut.PC.pc_o;
        st_tr[0] = dut.IF_stall_signal;
        fl_tr[0] = dut.IF_flush_signal;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk_i);
            #1;
            pc_tr[i] = dut.PC.pc_o;
            st_tr[i] = dut.IF_stall_signal;
            fl_tr[i] = dut.IF_flush_signal;
        end
    endtask

    // Sequential instruction-set interpreter: one instruction at a time, no pipeline notion.
    task automatic iss(input int n);
        logic [31:0] pc, ins, a, b, imm, nxt, addr;
        int steps;
        pc = 32'd0;
        steps = 0;
        while (int'(pc) < 4 * n && steps < 1000) begin
            ins = prog[pc[9:2]];
            a = m_reg[ins[25:21]];
            b = m_reg[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            addr = a + imm;
            nxt = pc + 32'd4;
            case (ins[31:26])
                T_RTYPE: case (ins[5:0])
                    T_ADD: m_reg[ins[15:11]] = a + b;
                    T_SUB: m_reg[ins[15:11]] = a - b;
                    T_AND: m_reg[ins[15:11]] = a & b;
                    T_OR:  m_reg[ins[15:11]] = a | b;
                    T_MUL: m_reg[ins[15:11]] = a * b;
                    default: ;
                endcase
                T_ADDI: m_reg[ins[20:16]] = a + imm;
                T_LW:   m_reg[ins[20:16]] = m_mem[addr[7:0]];
                T_SW:   m_mem[addr[7:0]] = b;
                T_BEQ:  if (a == b) nxt = pc + 32'd4 + (imm << 2);
                T_J:    nxt = {nxt[31:28], ins[25:0], 2'b00};
                default: ;
            endcase
            m_reg[0] = 32'd0;
            pc = nxt;
            steps++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (dut.PC.pc_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_pc: got %h expected 00000000", dut.PC.pc_o);
        end
        tests_run++;
        if (dut.IF_stall_signal !== 1'b0 || dut.IF_flush_signal !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: stall=%b flush=%b expected 0 0", dut.IF_stall_signal, dut.IF_flush_signal);
        end
    endtask

    task automatic test_pc_advance();
        int bad_sf;
        init_model();
        start_run();
        run(12);
        bad_sf = 0;
        for (int i = 0; i <= 12; i++) begin
            tests_run++;
            if (pc_tr[i] !== 32'(4 * i)) begin
                tests_failed++;
                $display("FAIL pc_advance[%0d]: got %h expected %h", i, pc_tr[i], 32'(4 * i));
            end
            if (st_tr[i] !== 1'b0 || fl_tr[i] !== 1'b0) bad_sf++;
        end
        tests_run++;
        if (bad_sf != 0) begin
            tests_failed++;
            $display("FAIL nop_stall_flush: %0d cycles with stall/flush set, expected 0", bad_sf);
        end
        for (int r = 0; r < 32; r++) begin
            tests_run++;
            if (dut.Registers.register[r] !== m_reg[r]) begin
                tests_failed++;
                $display("FAIL nop_reg[%0d]: got %h expected %h", r, dut.Registers.register[r], m_reg[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        logic [31:0] exp_v [0:3];
        exp_v[0] = 32'd7; exp_v[1] = 32'd3; exp_v[2] = 32'd4; exp_v[3] = 32'd21;
        init_model();
        prog[0] = enc_i(T_ADDI, 8, 0, 16'd7);
        prog[1] = enc_i(T_ADDI, 9, 0, 16'd3);
        prog[2] = enc_r(T_SUB, 10, 8, 9);
        prog[3] = enc_r(T_MUL, 11, 8, 9);
        start_run();
        run(14);
        stalls = 0;
        for (int i = 0; i <= 14; i++) if (st_tr[i] === 1'b1) stalls++;
        tests_run++;
        if (stalls != 0) begin
            tests_failed++;
            $display("FAIL fwd_stall_count: got %0d expected 0", stalls);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (dut.Registers.register[8 + k] !== exp_v[k]) begin
                tests_failed++;
                $display("FAIL fwd_reg[%0d]: got %h expected %h", 8 + k, dut.Registers.register[8 + k], exp_v[k]);
            end
        end
    endtask

    task automatic test_load_use();
        int stalls, idx;
        init_model();
        m_mem[0] = 32'd5;
        prog[0] = enc_i(T_LW, 8, 0, 16'd0);
        prog[1] = enc_r(T_ADD, 9, 8, 8);
        start_run();
        run(14);
        stalls = 0;
        idx = 0;
        for (int i = 0; i < 14; i++) if (st_tr[i] === 1'b1) begin stalls++; idx = i; end
        tests_run++;
        if (stalls != 1) begin
            tests_failed++;
            $display("FAIL loaduse_stall_count: got %0d expected 1", stalls);
        end
        tests_run++;
        if (pc_tr[idx + 1] !== pc_tr[idx] || pc_tr[idx] !== 32'd8) begin
            tests_failed++;
            $display("FAIL loaduse_pc_hold: got %h then %h expected 00000008 held", pc_tr[idx], pc_tr[idx + 1]);
        end
        tests_run++;
        if (dut.Registers.register[9] !== 32'd10) begin
            tests_failed++;
            $display("FAIL loaduse_t1: got %h expected 0000000a", dut.Registers.register[9]);
        end
    endtask

    task automatic test_store_load();
        init_model();
        m_mem[4] = 32'hdead_beef;
        prog[0] = enc_i(T_ADDI, 8, 0, 16'd9);
        prog[1] = enc_i(T_SW, 8, 0, 16'd4);
        prog[2] = enc_i(T_LW, 9, 0, 16'd4);
        start_run();
        run(12);
        tests_run++;
        if (dut.Data_Memory.memory[4] !== 32'd9) begin
            tests_failed++;
            $display("FAIL sw_mem4: got %h expected 00000009", dut.Data_Memory.memory[4]);
        end
        tests_run++;
        if (dut.Registers.register[9] !== 32'd9) begin
            tests_failed++;
            $display("FAIL lw_t1: got %h expected 00000009", dut.Registers.register[9]);
        end
    endtask

    task automatic test_branch_jump(input bit use_jump);
        int flushes, idx;
        logic [31:0] exp_pc;
        init_model();
        m_reg[16] = 32'd0;
        m_reg[17] = 32'd100;
        prog[0] = use_jump ? enc_j(26'd5) : enc_i(T_BEQ, 0, 0, 16'd1);
        prog[1] = enc_i(T_ADDI, 16, 0, 16'd1);
        if (use_jump) prog[5] = enc_i(T_ADDI, 17, 0, 16'd2);
        else          prog[2] = enc_i(T_ADDI, 17, 0, 16'd2);
        exp_pc = use_jump ? 32'd20 : 32'd8;
        start_run();
        run(14);
        flushes = 0;
        idx = 0;
        for (int i = 0; i < 14; i++) if (fl_tr[i] === 1'b1) begin flushes++; idx = i; end
        tests_run++;
        if (flushes != 1) begin
            tests_failed++;
            $display("FAIL %s_flush_count: got %0d expected 1", use_jump ? "jump" : "beq", flushes);
        end
        tests_run++;
        if (pc_tr[idx + 1] !== exp_pc) begin
            tests_failed++;
            $display("FAIL %s_target_pc: got %h expected %h", use_jump ? "jump" : "beq", pc_tr[idx + 1], exp_pc);
        end
        tests_run++;
        if (dut.Registers.register[16] !== 32'd0) begin
            tests_failed++;
            $display("FAIL %s_s0: got %h expected 00000000", use_jump ? "jump" : "beq", dut.Registers.register[16]);
        end
        tests_run++;
        if (dut.Registers.register[17] !== 32'd2) begin
            tests_failed++;
            $display("FAIL %s_s1: got %h expected 00000002", use_jump ? "jump" : "beq", dut.Registers.register[17]);
        end
    endtask

    task automatic test_random_programs();
        int n, kind;
        logic [5:0] fns [0:4];
        fns[0] = T_ADD; fns[1] = T_SUB; fns[2] = T_AND; fns[3] = T_OR; fns[4] = T_MUL;
        n = 24;
        for (int p = 0; p < 6; p++) begin
            init_model();
            for (int k = 0; k < n; k++) begin
                kind = $urandom_range(0, 9);
                case (kind)
                    0, 1, 2, 3, 4: prog[k] = enc_r(fns[$urandom_range(0, 4)], $urandom_range(0, 7),
                                                   $urandom_range(0, 7), $urandom_range(0, 7));
                    5, 9: prog[k] = enc_i(T_ADDI, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
                    6: prog[k] = enc_i(T_LW, $urandom_range(0, 7), 0, 16'(4 * $urandom_range(0, 15)));
                    7: prog[k] = enc_i(T_SW, $urandom_range(0, 7), 0, 16'(4 * $urandom_range(0, 15)));
                    default: prog[k] = enc_i(T_BEQ, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 2)));
                endcase
            end
            start_run();
            iss(n);
            run(90);
            for (int r = 0; r < 32; r++) begin
                tests_run++;
                if (dut.Registers.register[r] !== m_reg[r]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_reg[%0d]: got %h expected %h", p, r, dut.Registers.register[r], m_reg[r]);
                end
            end
            for (int a = 0; a < 64; a += 4) begin
                tests_run++;
                if (dut.Data_Memory.memory[a] !== m_mem[a]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_mem[%0d]: got %h expected %h", p, a, dut.Data_Memory.memory[a], m_mem[a]);
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        init_model();
        prog[0] = enc_i(T_ADDI, 18, 0, 16'd55);
        prog[1] = enc_i(T_SW, 18, 0, 16'd8);
        start_run();
        run(8);
        tests_run++;
        if (pc_tr[8] !== 32'd32) begin
            tests_failed++;
            $display("FAIL midrst_pc_before: got %h expected 00000020", pc_tr[8]);
        end
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (dut.PC.pc_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL midrst_pc_async: got %h expected 00000000", dut.PC.pc_o);
        end
        tests_run++;
        if (dut.Registers.register[18] !== 32'd55) begin
            tests_failed++;
            $display("FAIL midrst_reg_kept: got %h expected 00000037", dut.Registers.register[18]);
        end
        tests_run++;
        if (dut.Data_Memory.memory[8] !== 32'd55) begin
            tests_failed++;
            $display("FAIL midrst_mem_kept: got %h expected 00000037", dut.Data_Memory.memory[8]);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        start_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pc_advance();
        test_back_to_back();
        test_load_use();
        test_store_load();
        test_branch_jump(1'b0);
        test_branch_jump(1'b1);
        test_random_programs();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
